// File: rtl/bn_out_serializer.sv
// Serializes a packed vector of FP16 elements from the Bn output into a
// valid/ready element stream, highest lane first.
//   clk         : rising-edge clock
//   reset       : synchronous active-low reset
//   in_vec      : packed input vector, lane i at [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i]
//   in_valid    : in_vec holds a valid vector
//   in_ready    : vector accepted this cycle (combinational)
//   out_data    : current serial element
//   out_valid   : out_data is valid
//   out_ready   : downstream accepts out_data
//   out_idx     : lane number of out_data
//   out_last    : out_data is lane 0 of the vector (combinational)
//   out_special : out_data exponent is all ones, Inf or NaN (combinational)
//   vec_count   : fully emitted vectors, wraps modulo 2^16
module bn_out_serializer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned size       = 4,
  parameter int unsigned IDX_W      = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_WIDTH*size-1:0] in_vec,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [IDX_W-1:0]           out_idx,
  output logic                       out_last,
  output logic                       out_special,
  output logic [15:0]                vec_count
);

  localparam int unsigned      VEC_W   = DATA_WIDTH * size;
  localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(size - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t           state;
  logic [VEC_W-1:0] hold;
  logic             in_xfer;
  logic             el_xfer;

  // Extract one element from a packed vector.
  function automatic logic [DATA_WIDTH-1:0] lane(input logic [VEC_W-1:0] v,
                                                 input logic [IDX_W-1:0] i);
    return v[DATA_WIDTH*32'(i) +: DATA_WIDTH];
  endfunction

  // Handshake decode; a new vector may enter on the same edge the last
  // element leaves, so back-to-back vectors stream without a bubble.
  assign out_last    = (state == SEND) && (out_idx == '0);
  assign el_xfer     = out_valid & out_ready;
  assign in_ready    = reset & ((state == IDLE) | (out_last & el_xfer));
  assign in_xfer     = in_valid & in_ready;
  assign out_special = out_valid & (out_data[14:10] == 5'h1F);

  // Serializer FSM with registered element outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      hold      <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
      vec_count <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_xfer) begin
            hold      <= in_vec;
            out_data  <= lane(in_vec, TOP_IDX);
            out_idx   <= TOP_IDX;
            out_valid <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (el_xfer) begin
            if (out_last) begin
              vec_count <= vec_count + 16'd1;
              if (in_xfer) begin
                hold     <= in_vec;
                out_data <= lane(in_vec, TOP_IDX);
                out_idx  <= TOP_IDX;
              end else begin
                state     <= IDLE;
                out_valid <= 1'b0;
                out_idx   <= '0;
                out_data  <= '0;
              end
            end else begin
              out_idx  <= IDX_W'(out_idx - 1'b1);
              out_data <= lane(hold, IDX_W'(out_idx - 1'b1));
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/bn_out_serializer.md
BN_OUT_SERIALIZER -- requirements
Module: bn_out_serializer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, meaning the width of one FP16 element.
REQ-002 The block SHALL have parameter size, default 4, meaning the number of elements per packed vector; legal values are 2 or more.
REQ-003 The block SHALL have parameter IDX_W, default 2, meaning the index width, equal to clog2(size).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-006 The block SHALL have port in_vec, input, DATA_WIDTH*size bits: packed vector from the Bn output.
REQ-007 The block SHALL have port in_valid, input, 1 bit: in_vec holds a valid vector.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block accepts in_vec this cycle.
REQ-009 The block SHALL have port out_data, output, DATA_WIDTH bits: current serial element.
REQ-010 The block SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the downstream accepts out_data.
REQ-012 The block SHALL have port out_idx, output, IDX_W bits: lane number of out_data.
REQ-013 The block SHALL have port out_last, output, 1 bit: out_data is the final element of the vector.
REQ-014 The block SHALL have port out_special, output, 1 bit: out_data exponent bits [14:10] equal 5'h1F (Inf or NaN).
REQ-015 The block SHALL have port vec_count, output, 16 bits: number of fully emitted vectors, wrapping modulo 2^16.

Function
REQ-016 Lane i SHALL be in_vec[DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i]; emission order SHALL run from lane size-1 down to lane 0.
REQ-017 The FSM SHALL have states IDLE and SEND; reset enters IDLE.
REQ-018 A vector transfer SHALL occur on a rising edge when in_valid and in_ready are both 1; the whole in_vec is captured into an internal holding register.
REQ-019 in_ready SHALL be 1 in IDLE, and 1 in SEND only when out_last, out_valid and out_ready are all 1; it SHALL be 0 otherwise, combinational from state and out_ready.
REQ-020 After a transfer at edge N, out_valid=1, out_idx=size-1 and out_data=lane size-1 SHALL hold from edge N onward, a latency of 1 cycle.
REQ-021 An element transfer SHALL occur when out_valid and out_ready are both 1; out_idx then decrements by 1.
REQ-022 While out_valid=1 and out_ready=0, out_data, out_idx, out_last and out_special SHALL hold stable.
REQ-023 out_last SHALL be 1 exactly when in SEND with out_idx==0.
REQ-024 On the last-element transfer with no simultaneous vector transfer, the FSM SHALL return to IDLE and out_valid SHALL fall to 0.
REQ-025 On the last-element transfer with a simultaneous vector transfer, the FSM SHALL stay in SEND with no bubble cycle; the next edge presents lane size-1 of the new vector.
REQ-026 vec_count SHALL increment by 1 on each last-element transfer and wrap from 16'hFFFF to 0.
REQ-027 out_special SHALL be combinational from out_data and SHALL be 0 when out_valid=0.
REQ-028 In IDLE, out_data and out_idx SHALL be 0.
REQ-029 Element values SHALL pass bit-exact; no arithmetic is performed on element data.

Reset
REQ-030 While reset=0 at a rising edge, the block SHALL set state=IDLE, the holding register=0, out_valid=0, out_idx=0, out_data=0, vec_count=0 and in_ready=0.
REQ-031 in_ready SHALL rise to 1 in the first cycle after reset returns to 1.
REQ-032 Reset asserted mid-vector SHALL discard the remaining elements with no partial vec_count increment.

Verification
REQ-033 Scenario: in_vec=64'h4000_4200_4400_4500 with out_ready held 1 -> out_data sequence 4000, 4200, 4400, 4500; out_idx 3, 2, 1, 0; out_last only on 4500; vec_count=1.
REQ-034 Scenario: out_ready toggled 1,0,0,1,... during the same vector -> out_data held during stalls, no element lost or duplicated, in_ready=0 until the last transfer.
REQ-035 Scenario: a second vector 64'h3C00_4000_4200_4400 offered during the last element -> 8 consecutive valid cycles with no gap, vec_count=2.
REQ-036 Scenario: in_vec=64'h7C00_FE00_0000_8000 -> out_special sequence 1, 1, 0, 0.
REQ-037 Scenario: reset=0 driven after 2 elements, then released -> out_valid=0, vec_count=0; the next vector is emitted from lane 3.
REQ-038 Scenario: 65536 back-to-back vectors -> vec_count wraps to 0.
